// File: rtl/l2_req_pkg.sv
// Shared types and sizing for the L2 request issuer: entry states, depth helper
// and the entry record layout at the default widths.
package l2_req_pkg;

    localparam int unsigned CREG_ID_BITS_DEF = 3;
    localparam int unsigned ADDR_WIDTH_DEF   = 32;
    localparam int unsigned DATA_WIDTH_DEF   = 32;

    function automatic int unsigned depth_of(input int unsigned id_bits);
        return 32'd1 << id_bits;
    endfunction

    localparam int unsigned DEPTH_DEF = 32'd1 << CREG_ID_BITS_DEF;

    typedef enum logic [1:0] {
        ENT_FREE       = 2'd0,
        ENT_WAIT_ISSUE = 2'd1,
        ENT_WAIT_DATA  = 2'd2,
        ENT_DONE       = 2'd3
    } entry_state_e;

    typedef struct packed {
        entry_state_e                state;
        logic                        rw;
        logic [ADDR_WIDTH_DEF-1:0]   addr;
        logic [DATA_WIDTH_DEF-1:0]   data;
    } entry_t;

endpackage

// File: rtl/l2_req_data_store.sv
// Per-entry read-data array: cleared on allocate, filled by L2 response,
// read at the retire pointer.
module l2_req_data_store #(
    parameter int unsigned ID_BITS    = 3,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_alloc_we,
    input  logic [ID_BITS-1:0]    i_alloc_idx,
    input  logic                  i_rsp_we,
    input  logic [ID_BITS-1:0]    i_rsp_idx,
    input  logic [DATA_WIDTH-1:0] i_rsp_data,
    input  logic [ID_BITS-1:0]    i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 32'd1 << ID_BITS;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_alloc_we) r_mem[i_alloc_idx] <= '0;
            if (i_rsp_we)   r_mem[i_rsp_idx]   <= i_rsp_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/l2_req_issuer.sv
// In-order load/store queue toward the L2: allocate at tail, issue at iss,
// collect read data by ID, retire at head in program order.
module l2_req_issuer
    import l2_req_pkg::*;
#(
    parameter int unsigned CREG_ID_BITS = CREG_ID_BITS_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    output logic                    req_ready,
    output logic [ADDR_WIDTH-1:0]   l2_addr,
    output logic [DATA_WIDTH-1:0]   l2_data,
    output logic                    l2_rw,
    output logic                    l2_valid,
    output logic [CREG_ID_BITS-1:0] l2_id,
    input  logic                    l2_stall,
    input  logic [DATA_WIDTH-1:0]   l2_rdata,
    input  logic [CREG_ID_BITS-1:0] l2_rid,
    input  logic                    l2_rready,
    output logic                    rsp_valid,
    output logic                    rsp_rw,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    input  logic                    rsp_ready,
    output logic                    err_spurious
);

    localparam int unsigned DEPTH = depth_of(CREG_ID_BITS);
    localparam logic [CREG_ID_BITS:0] FULL_CNT = (CREG_ID_BITS+1)'(DEPTH);

    entry_state_e            r_state [DEPTH];
    logic                    r_rw    [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_addr  [DEPTH];
    logic [DATA_WIDTH-1:0]   r_wdata [DEPTH];

    logic [CREG_ID_BITS-1:0] r_tail, r_iss, r_head;
    logic [CREG_ID_BITS:0]   r_count;
    logic                    r_err;

    logic                    w_full, w_alloc, w_issue_vld, w_issue;
    logic                    w_resp_hit, w_resp_bad, w_rsp_vld, w_retire;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    assign w_full      = (r_count == FULL_CNT);
    assign w_alloc     = req_valid & ~w_full;
    assign w_issue_vld = (r_state[r_iss] == ENT_WAIT_ISSUE);
    assign w_issue     = w_issue_vld & ~l2_stall;
    assign w_resp_hit  = l2_rready & (r_state[l2_rid] == ENT_WAIT_DATA);
    assign w_resp_bad  = l2_rready & ~w_resp_hit;
    assign w_rsp_vld   = (r_state[r_head] == ENT_DONE);
    assign w_retire    = w_rsp_vld & rsp_ready;

    // The four events always touch distinct entries, so their updates never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_state[i] <= ENT_FREE;
            r_tail  <= '0;
            r_iss   <= '0;
            r_head  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_state[r_tail] <= ENT_WAIT_ISSUE;
                r_tail          <= r_tail + CREG_ID_BITS'(1);
            end
            if (w_issue) begin
                r_state[r_iss] <= r_rw[r_iss] ? ENT_DONE : ENT_WAIT_DATA;
                r_iss          <= r_iss + CREG_ID_BITS'(1);
            end
            if (w_resp_hit) r_state[l2_rid] <= ENT_DONE;
            if (w_resp_bad) r_err <= 1'b1;
            if (w_retire) begin
                r_state[r_head] <= ENT_FREE;
                r_head          <= r_head + CREG_ID_BITS'(1);
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + (CREG_ID_BITS+1)'(1);
                2'b01:   r_count <= r_count - (CREG_ID_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_rw[r_tail]    <= req_rw;
            r_addr[r_tail]  <= req_addr;
            r_wdata[r_tail] <= req_data;
        end
    end

    l2_req_data_store #(
        .ID_BITS    (CREG_ID_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_data_store (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_alloc_we  (w_alloc),
        .i_alloc_idx (r_tail),
        .i_rsp_we    (w_resp_hit),
        .i_rsp_idx   (l2_rid),
        .i_rsp_data  (l2_rdata),
        .i_rd_idx    (r_head),
        .o_rd_data   (w_rd_data)
    );

    assign req_ready    = ~w_full;
    assign l2_valid     = w_issue_vld;
    assign l2_id        = r_iss;
    assign l2_addr      = w_issue_vld ? r_addr[r_iss]  : '0;
    assign l2_data      = w_issue_vld ? r_wdata[r_iss] : '0;
    assign l2_rw        = w_issue_vld & r_rw[r_iss];
    assign rsp_valid    = w_rsp_vld;
    assign rsp_rw       = w_rsp_vld & r_rw[r_head];
    assign rsp_data     = (w_rsp_vld & ~r_rw[r_head]) ? w_rd_data : '0;
    assign err_spurious = r_err;

endmodule

// File: tb/tb_l2_req_issuer.sv
// Directed bench for l2_req_issuer: inputs change on negedge, outputs checked on negedge.
module tb_l2_req_issuer;

    logic        clk;
    logic        reset;
    logic        req_valid, req_rw, req_ready;
    logic [31:0] req_addr, req_data;
    logic [31:0] l2_addr, l2_data, l2_rdata;
    logic        l2_rw, l2_valid, l2_stall, l2_rready;
    logic [2:0]  l2_id, l2_rid;
    logic        rsp_valid, rsp_rw, rsp_ready, err_spurious;
    logic [31:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    l2_req_issuer #(
        .CREG_ID_BITS (3),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .l2_addr      (l2_addr),
        .l2_data      (l2_data),
        .l2_rw        (l2_rw),
        .l2_valid     (l2_valid),
        .l2_id        (l2_id),
        .l2_stall     (l2_stall),
        .l2_rdata     (l2_rdata),
        .l2_rid       (l2_rid),
        .l2_rready    (l2_rready),
        .rsp_valid    (rsp_valid),
        .rsp_rw       (rsp_rw),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .err_spurious (err_spurious)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, 1);
        chk({pfx, "_l2_valid"},  l2_valid, 0);
        chk({pfx, "_l2_addr"},   l2_addr, 0);
        chk({pfx, "_l2_data"},   l2_data, 0);
        chk({pfx, "_l2_rw"},     l2_rw, 0);
        chk({pfx, "_l2_id"},     l2_id, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_rw"},    rsp_rw, 0);
        chk({pfx, "_rsp_data"},  rsp_data, 0);
        chk({pfx, "_err"},       err_spurious, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0; req_valid = 0; req_rw = 0; req_addr = 0; req_data = 0;
        l2_stall = 0; l2_rdata = 0; l2_rid = 0; l2_rready = 0; rsp_ready = 0;
        repeat (2) tick();
        chk_reset_outputs("rst");
        reset = 1'b1;
        tick();

        // single read, response 3 cycles after issue
        req_valid = 1; req_rw = 0; req_addr = 32'h0000_0100; req_data = 32'h0;
        tick();
        req_valid = 0;
        chk("t1_l2_valid", l2_valid, 1);
        chk("t1_l2_id", l2_id, 0);
        chk("t1_l2_addr", l2_addr, 32'h0000_0100);
        chk("t1_l2_rw", l2_rw, 0);
        tick();
        chk("t1_l2_valid_after_issue", l2_valid, 0);
        tick(); tick();
        chk("t1_rsp_valid_early", rsp_valid, 0);
        l2_rready = 1; l2_rid = 0; l2_rdata = 32'hDEAD_BEEF;
        tick();
        l2_rready = 0;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_rw", rsp_rw, 0);
        chk("t1_rsp_data", rsp_data, 32'hDEAD_BEEF);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("t1_rsp_valid_after", rsp_valid, 0);

        // three reads, responses 2,0,1, retire 0,1,2
        do_reset();
        req_valid = 1; req_rw = 0; req_addr = 32'h200;
        tick();
        chk("t2_id0", l2_id, 0); chk("t2_addr0", l2_addr, 32'h200);
        req_addr = 32'h204;
        tick();
        chk("t2_id1", l2_id, 1); chk("t2_addr1", l2_addr, 32'h204);
        req_addr = 32'h208;
        tick();
        req_valid = 0;
        chk("t2_id2", l2_id, 2); chk("t2_addr2", l2_addr, 32'h208);
        tick();
        chk("t2_l2_idle", l2_valid, 0);
        l2_rready = 1; l2_rid = 2; l2_rdata = 32'hA2A2_2222;
        tick();
        chk("t2_no_rsp_yet", rsp_valid, 0);
        l2_rid = 0; l2_rdata = 32'hA0A0_0000;
        tick();
        chk("t2_rsp0_valid", rsp_valid, 1);
        chk("t2_rsp0_data", rsp_data, 32'hA0A0_0000);
        l2_rid = 1; l2_rdata = 32'hA1A1_1111; rsp_ready = 1;
        tick();
        l2_rready = 0;
        chk("t2_rsp1_valid", rsp_valid, 1);
        chk("t2_rsp1_data", rsp_data, 32'hA1A1_1111);
        tick();
        chk("t2_rsp2_valid", rsp_valid, 1);
        chk("t2_rsp2_data", rsp_data, 32'hA2A2_2222);
        tick();
        rsp_ready = 0;
        chk("t2_drained", rsp_valid, 0);

        // fill under stall, ninth accepted after first retire
        do_reset();
        l2_stall = 1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1; req_rw = 1;
            req_addr = 32'h1000 + i * 4;
            req_data = 32'hC000_0000 + i;
            chk("t3_ready_fill", req_ready, 1);
            tick();
            chk("t3_stall_valid", l2_valid, 1);
            chk("t3_stall_id", l2_id, 0);
            chk("t3_stall_addr", l2_addr, 32'h1000);
            chk("t3_stall_data", l2_data, 32'hC000_0000);
        end
        req_addr = 32'h1020; req_data = 32'hC000_0008;
        for (int i = 0; i < 2; i++) begin
            chk("t3_full", req_ready, 0);
            tick();
            chk("t3_hold_id", l2_id, 0);
            chk("t3_hold_rw", l2_rw, 1);
        end
        l2_stall = 0;
        tick();
        chk("t3_wr_rsp_valid", rsp_valid, 1);
        chk("t3_wr_rsp_rw", rsp_rw, 1);
        chk("t3_wr_rsp_data", rsp_data, 0);
        chk("t3_next_id", l2_id, 1);
        chk("t3_still_full", req_ready, 0);
        l2_stall = 1; rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("t3_ready_after_retire", req_ready, 1);
        chk("t3_head_not_done", rsp_valid, 0);
        tick();
        req_valid = 0;
        chk("t3_ninth_accepted", req_ready, 0);
        l2_stall = 0;

        // write then read with stall pulse
        do_reset();
        req_valid = 1; req_rw = 1; req_addr = 32'h40; req_data = 32'h5555_5555;
        tick();
        req_rw = 0; req_addr = 32'h80; req_data = 32'h0; l2_stall = 1;
        chk("t4_wr_id", l2_id, 0);
        chk("t4_wr_rw", l2_rw, 1);
        chk("t4_wr_addr", l2_addr, 32'h40);
        chk("t4_wr_data", l2_data, 32'h5555_5555);
        tick();
        req_valid = 0;
        chk("t4_stall_id_a", l2_id, 0);
        tick();
        l2_stall = 0;
        chk("t4_stall_id_b", l2_id, 0);
        chk("t4_stall_addr_b", l2_addr, 32'h40);
        chk("t4_no_rsp", rsp_valid, 0);
        tick();
        chk("t4_rd_id", l2_id, 1);
        chk("t4_rd_rw", l2_rw, 0);
        chk("t4_rd_addr", l2_addr, 32'h80);
        chk("t4_wr_rsp_valid", rsp_valid, 1);
        chk("t4_wr_rsp_rw", rsp_rw, 1);
        chk("t4_wr_rsp_data", rsp_data, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("t4_rsp_gap", rsp_valid, 0);
        chk("t4_l2_idle", l2_valid, 0);
        l2_rready = 1; l2_rid = 1; l2_rdata = 32'h8080_8080;
        tick();
        l2_rready = 0;
        chk("t4_rd_rsp_valid", rsp_valid, 1);
        chk("t4_rd_rsp_rw", rsp_rw, 0);
        chk("t4_rd_rsp_data", rsp_data, 32'h8080_8080);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("t4_drained", rsp_valid, 0);

        // spurious response to a FREE entry
        chk("t5_err_before", err_spurious, 0);
        l2_rready = 1; l2_rid = 5; l2_rdata = 32'hBAD0_0005;
        tick();
        l2_rready = 0;
        chk("t5_err_set", err_spurious, 1);
        tick(); tick();
        chk("t5_err_sticky", err_spurious, 1);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_l2_valid", l2_valid, 0);
        chk("t5_req_ready", req_ready, 1);
        req_valid = 1; req_rw = 0; req_addr = 32'h300;
        tick();
        req_valid = 0;
        chk("t5_next_id", l2_id, 2);
        chk("t5_next_addr", l2_addr, 32'h300);

        // reset with reads in flight, then a late response
        do_reset();
        chk("t6_err_cleared", err_spurious, 0);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_rw = 0; req_addr = 32'h400 + i * 4;
            tick();
        end
        req_valid = 0;
        tick();
        chk("t6_all_waiting", l2_valid, 0);
        chk("t6_no_rsp", rsp_valid, 0);
        reset = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        tick();
        reset = 1'b1;
        tick();
        l2_rready = 1; l2_rid = 2; l2_rdata = 32'h1234_5678;
        tick();
        l2_rready = 0;
        chk("t6_late_err", err_spurious, 1);
        chk("t6_late_no_rsp", rsp_valid, 0);
        req_valid = 1; req_rw = 0; req_addr = 32'h500;
        tick();
        req_valid = 0;
        chk("t6_new_valid", l2_valid, 1);
        chk("t6_new_id", l2_id, 0);
        chk("t6_new_addr", l2_addr, 32'h500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l2_req_issuer.md
# l2_req_issuer

In-order load/store request queue that drives the core-side request port of the L2 cache and collects its responses. It accepts one memory op per cycle from the core pipeline and tags each with a queue-entry ID. It issues ops to the L2 in program order, honouring the L2's combinational stall. Read data is captured out of order by ID and retired to the core in program order.

## Interface
- CREG_ID_BITS, 3, entry ID width; queue depth DEPTH = 2**CREG_ID_BITS
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (one cache line)

- clk  in  1  sole clock; all state on posedge
- reset  in  1  asynchronous, active-low; clears all state
- req_valid  in  1  core presents an op
- req_rw  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  op address
- req_data  in  DATA_WIDTH  write data
- req_ready  out  1  queue can accept; equals ~full
- l2_addr  out  ADDR_WIDTH  to L2 addr_in
- l2_data  out  DATA_WIDTH  to L2 data_in
- l2_rw  out  1  to L2 rw_in
- l2_valid  out  1  to L2 valid_in
- l2_id  out  CREG_ID_BITS  to L2 id_in; the entry index
- l2_stall  in  1  from L2 stall_out
- l2_rdata  in  DATA_WIDTH  from L2 data_out
- l2_rid  in  CREG_ID_BITS  from L2 id_out
- l2_rready  in  1  from L2 ready_out; read completion
- rsp_valid  out  1  head op complete
- rsp_rw  out  1  head op type
- rsp_data  out  DATA_WIDTH  read data; 0 for writes
- rsp_ready  in  1  core takes response
- err_spurious  out  1  sticky; response arrived for an entry not in WAIT_DATA

## Operation
- Each entry has one of 4 states: FREE, WAIT_ISSUE, WAIT_DATA, DONE.
- There are 3 circular pointers, each CREG_ID_BITS wide with natural wrap: tail (alloc), iss (next to issue), head (retire).
- There is 1 count register (CREG_ID_BITS+1 bits). full = (count == DEPTH); empty = (count == 0).
- **Allocate:** when req_valid & req_ready, entry[tail] ← {WAIT_ISSUE, addr, data, rw}, then tail++ and count++.
- **Issue:**
  - l2_valid = (entry[iss].state == WAIT_ISSUE). l2_addr, l2_data, l2_rw and l2_id are driven from entry[iss], with l2_id = iss.
  - An op is accepted at the posedge where l2_valid & ~l2_stall. Then iss++.
  - On acceptance a read becomes WAIT_DATA and a write becomes DONE.
  - While l2_valid & l2_stall, all l2_* outputs hold stable.
- **Response:**
  - When l2_rready and entry[l2_rid] is WAIT_DATA: store l2_rdata, state ← DONE.
  - Otherwise the response is ignored and err_spurious is set (sticky until reset).
- **Retire:**
  - rsp_valid = (entry[head].state == DONE). rsp_rw and rsp_data come from entry[head].
  - On rsp_valid & rsp_ready: entry[head] ← FREE, then head++ and count--.
- **Simultaneous events:**
  - Allocate and retire in the same cycle leave count unchanged.
  - Allocate, issue, response and retire can all occur in one cycle on distinct entries.
  - A response and an issue to the same entry cannot coincide, since issue precedes WAIT_DATA.
- **Full:** req_ready is 0 when full. There is no same-cycle bypass from retire to allocate.
- **Reset:**
  - Values: all entries FREE, all pointers 0, count 0, err_spurious 0, rsp_data 0.
  - A reset mid-operation drops all in-flight ops. Late L2 responses then hit FREE entries: they are ignored and set err_spurious.

## Timing
- Output reset values: req_ready = 1, l2_valid = 0, l2_addr/l2_data/l2_rw/l2_id = 0, rsp_valid = 0, rsp_rw = 0, rsp_data = 0, err_spurious = 0.
- Request accepted at edge N → l2_valid high during cycle N+1, earliest.
- Write: L2 accepts at edge M → rsp_valid high from cycle M+1.
- Read: l2_rready sampled at edge R → rsp_valid high from cycle R+1 (if that entry is at head).
- Throughput is 1 op/cycle on each of the allocate, issue and retire paths.
- l2_valid is driven from registered state only. It has no combinational path from l2_stall, which avoids a loop with the L2 stall_out.

## Structure
- Shared package l2_req_pkg holds:
  - the entry-state enum {FREE, WAIT_ISSUE, WAIT_DATA, DONE}, 2 bits;
  - DEPTH derived from CREG_ID_BITS;
  - the entry record type {state, rw, addr, data}.
- One sub-module, l2_req_data_store: a DEPTH×DATA_WIDTH array with two write ports (allocate by tail, response by l2_rid) and one read port indexed by head.
- Pointers, the state FSM per entry, and the issue/retire logic stay in the top module.

## Test plan
- Reset, then 1 read to 0x0000_0100 with the L2 responding id 0, data 0xDEAD_BEEF, 3 cycles after issue → l2_id = 0; rsp_valid 1 cycle after l2_rready; rsp_data = 0xDEADBEEF.
- 3 reads (ids 0,1,2) with responses returned in order 2,0,1 → rsp_data retires in id order 0,1,2.
- 9 back-to-back requests with L2 stall held high → req_ready drops after 8 accepted; the 9th is accepted the cycle after the first retire; l2_* stable throughout the stall.
- Write to 0x40 followed by a read to 0x80, with stall pulsed for 2 cycles → the write retires with rsp_rw = 1 and rsp_data = 0 with no l2_rready; the read is issued only after the write is accepted.
- l2_rready with l2_rid = 5 while entry 5 is FREE → err_spurious = 1 and stays 1; queue contents unaffected.
- Assert reset with 4 entries in WAIT_DATA → all outputs at reset values; a later response sets err_spurious; the next request gets l2_id = 0.
